// File: rtl/act_unit_multimode.sv
// act_unit_multimode
// Run-time selectable activation engine (BYPASS / RELU / RELU6 / HSIGMOID /
// HSWISH) on LANES parallel signed fixed-point elements, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
// Three-stage valid/ready pipeline with full AXI4-Stream backpressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_mode[2:0]         activation select, sampled on the first beat of each packet
//   s_axis_*              input stream (tdata lane i = bits [i*DATA_WIDTH +: DATA_WIDTH])
//   m_axis_*              output stream, 3 cycles after acceptance
//   cfg_err               high in the cycle a packet is accepted with a reserved mode
module act_unit_multimode #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  cfg_mode,
    input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        cfg_err
);
    localparam logic [2:0] MODE_BYPASS = 3'd0;
    localparam logic [2:0] MODE_RELU   = 3'd1;
    localparam logic [2:0] MODE_RELU6  = 3'd2;
    localparam logic [2:0] MODE_HSIG   = 3'd3;
    localparam logic [2:0] MODE_HSWISH = 3'd4;

    // t needs one extra bit so x + 3.0 cannot wrap at the top of the range
    localparam int TW = DATA_WIDTH + 1;
    localparam int PW = DATA_WIDTH + TW;        // x * t
    localparam int QW = PW - FRAC_BITS;         // p after rescale
    localparam int KW = 16;                     // 1/6 constant as a positive signed value
    localparam int HW = TW + KW;                // t * INV6
    localparam int YW = QW + KW;                // p * INV6

    localparam logic signed [TW-1:0] C3 = TW'(3 << FRAC_BITS);
    localparam logic signed [TW-1:0] C6 = TW'(6 << FRAC_BITS);
    localparam int INV6    = 10923;             // round(2^16 / 6)
    localparam int HALF_F  = 1 << (FRAC_BITS - 1);
    localparam int ROUND16 = 1 << 15;
    localparam longint SAT_HI = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
    localparam longint SAT_LO = -(longint'(1) <<< (DATA_WIDTH - 1));

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [YW-1:0] v);
        if (v > YW'(SAT_HI))
            return DATA_WIDTH'(SAT_HI);
        else if (v < YW'(SAT_LO))
            return DATA_WIDTH'(SAT_LO);
        else
            return DATA_WIDTH'(v);
    endfunction

    // ---------------- control path ----------------
    logic       s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic       s1_last_reg, s2_last_reg, s3_last_reg;
    logic [2:0] s1_mode_reg, s2_mode_reg;
    logic       pkt_start_reg;
    logic [2:0] mode_lat_reg;
    logic       s1_ready, s2_ready, s3_ready;
    logic       s1_load, s2_load, s3_load;
    logic [2:0] mode_sel_next, mode_next;
    logic       mode_reserved;

    // Combinational ready chain: a stage may load if empty or draining this cycle
    assign s3_ready = !s3_valid_reg || m_axis_tready;
    assign s2_ready = !s2_valid_reg || s3_ready;
    assign s1_ready = !s1_valid_reg || s2_ready;
    assign s1_load  = s1_ready && s_axis_tvalid;
    assign s2_load  = s2_ready && s1_valid_reg;
    assign s3_load  = s3_ready && s2_valid_reg;

    assign s_axis_tready = s1_ready;
    assign m_axis_tvalid = s3_valid_reg;
    assign m_axis_tlast  = s3_last_reg;

    // The latched copy only ever holds a legal mode, so a reserved code can
    // only be seen on the first beat of a packet.
    always_comb begin
        mode_sel_next = pkt_start_reg ? cfg_mode : mode_lat_reg;
        mode_reserved = (mode_sel_next > MODE_HSWISH);
        mode_next     = mode_reserved ? MODE_BYPASS : mode_sel_next;
    end

    assign cfg_err = s1_load && pkt_start_reg && mode_reserved;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s3_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s2_last_reg   <= 1'b0;
            s3_last_reg   <= 1'b0;
            s1_mode_reg   <= MODE_BYPASS;
            s2_mode_reg   <= MODE_BYPASS;
            pkt_start_reg <= 1'b1;
            mode_lat_reg  <= MODE_BYPASS;
        end else begin
            if (s1_ready) s1_valid_reg <= s_axis_tvalid;
            if (s2_ready) s2_valid_reg <= s1_valid_reg;
            if (s3_ready) s3_valid_reg <= s2_valid_reg;
            if (s1_load) begin
                s1_mode_reg   <= mode_next;
                s1_last_reg   <= s_axis_tlast;
                pkt_start_reg <= s_axis_tlast;
                if (pkt_start_reg) mode_lat_reg <= mode_next;
            end
            if (s2_load) begin
                s2_mode_reg <= s1_mode_reg;
                s2_last_reg <= s1_last_reg;
            end
            if (s3_load) s3_last_reg <= s2_last_reg;
        end
    end

    // ---------------- per-lane datapath ----------------
    logic [LANES*DATA_WIDTH-1:0] out_data;
    assign m_axis_tdata = out_data;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] x_in;
        logic signed [TW-1:0]         t_sum, t_next;
        logic signed [DATA_WIDTH-1:0] s1_x_reg, s2_x_reg;
        logic signed [TW-1:0]         s1_t_reg;
        logic signed [PW-1:0]         xt_prod;
        logic signed [QW-1:0]         p_next, s2_p_reg;
        logic signed [HW-1:0]         ht_prod, h_next, s2_h_reg;
        logic signed [YW-1:0]         py_prod, y_next, h_ext;
        logic signed [TW-1:0]         x_ext;
        logic [DATA_WIDTH-1:0]        res_next, out_reg;

        assign x_in = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];

        // S1: t = clamp(x + 3, 0, 6)
        always_comb begin
            t_sum = TW'(x_in) + C3;
            if (t_sum[TW-1])
                t_next = '0;
            else if (t_sum > C6)
                t_next = C6;
            else
                t_next = t_sum;
        end

        // S2: p = round(x*t / 2^F) for h-swish, t/6 for h-sigmoid
        always_comb begin
            xt_prod = PW'(s1_x_reg) * PW'(s1_t_reg);
            p_next  = QW'((xt_prod + PW'(HALF_F)) >>> FRAC_BITS);
            ht_prod = HW'(s1_t_reg) * HW'(INV6);
            h_next  = (ht_prod + HW'(ROUND16)) >>> 16;
        end

        // S3: p/6, saturate, select by the mode carried with the beat
        always_comb begin
            py_prod  = YW'(s2_p_reg) * YW'(INV6);
            y_next   = (py_prod + YW'(ROUND16)) >>> 16;
            h_ext    = YW'(s2_h_reg);
            x_ext    = TW'(s2_x_reg);
            res_next = s2_x_reg;
            case (s2_mode_reg)
                MODE_RELU:   res_next = s2_x_reg[DATA_WIDTH-1] ? '0 : s2_x_reg;
                MODE_RELU6: begin
                    if (x_ext[TW-1])
                        res_next = '0;
                    else if (x_ext > C6)
                        res_next = DATA_WIDTH'(C6);
                    else
                        res_next = s2_x_reg;
                end
                MODE_HSIG:   res_next = sat(h_ext);
                MODE_HSWISH: res_next = sat(y_next);
                default:     res_next = s2_x_reg;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_x_reg <= '0;
                s1_t_reg <= '0;
                s2_x_reg <= '0;
                s2_p_reg <= '0;
                s2_h_reg <= '0;
                out_reg  <= '0;
            end else begin
                if (s1_load) begin
                    s1_x_reg <= x_in;
                    s1_t_reg <= t_next;
                end
                if (s2_load) begin
                    s2_x_reg <= s1_x_reg;
                    s2_p_reg <= p_next;
                    s2_h_reg <= h_next;
                end
                if (s3_load) out_reg <= res_next;
            end
        end

        assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_reg;
    end

endmodule

// File: doc/act_unit_multimode.md
Name: act_unit_multimode

Overview:
- Unified, run-time-selectable activation engine for the MobileNetV3 datapath. Supports bypass, ReLU, ReLU6, hard-sigmoid and h-swish on LANES parallel signed fixed-point lanes.
- Sits between conv/depthwise accumulator requantisation and the next layer's input stream, with full AXI4-Stream backpressure.
- Replaces the per-function single-lane blocks. Adds signed saturation, rounding, per-packet mode latching and correct stalling.

Parameters:
- DATA_WIDTH, 16, bits per lane element, signed two's complement.
- FRAC_BITS, 8, fractional bits (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- LANES, 1, parallel elements per beat (1..16).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  3  0=BYPASS, 1=RELU, 2=RELU6, 3=HSIGMOID, 4=HSWISH, 5-7 reserved.
- s_axis_tdata  in  LANES*DATA_WIDTH  input elements; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  LANES*DATA_WIDTH  activated elements.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  delayed tlast.
- cfg_err  out  1  one-cycle pulse when a packet starts with a reserved mode.

Behaviour:
- Reset (async assert, sync release): all pipeline valids 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, cfg_err=0. Packet-start flag = 1.
- Reset mid-operation: in-flight beats are discarded. No output beat appears until new input arrives.
- Mode latching:
  - cfg_mode is sampled on the first accepted beat of each packet, i.e. the first beat after reset or after an accepted tlast beat.
  - The latched mode applies to every beat through that packet's tlast. cfg_mode changes mid-packet are ignored.
  - Mode travels with the data through the pipeline.
  - A reserved mode is processed as BYPASS and pulses cfg_err in the acceptance cycle.
- Pipeline: 3 register stages; latency 3 cycles from input acceptance to m_axis_tvalid.
  - S1: x+3 and clamp.
  - S2: multiply and rescale.
  - S3: multiply by 1/6, round, saturate and select by mode.
- Handshake:
  - A stage loads when it is empty or its contents advance in the same cycle.
  - s_axis_tready = S1 can load. A combinational ready chain is permitted.
  - Throughput is 1 beat/cycle when m_axis_tready=1.
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
  - No beat is dropped or duplicated.
  - tvalid is never gated on tready.
- Arithmetic, per lane, x signed:
  - Constants: C3 = 3<<FRAC_BITS, C6 = 6<<FRAC_BITS, INV6 = 10923 (round(2^16/6)).
  - t = clamp(x + C3, 0, C6), computed in DATA_WIDTH+1 bits so there is no overflow at max positive x.
  - RELU = max(x, 0).
  - RELU6 = clamp(x, 0, C6).
  - HSIGMOID = (t*INV6 + 2^15) >>> 16.
  - HSWISH:
    - p = (x*t + 2^(FRAC_BITS-1)) >>> FRAC_BITS, using a full-width signed product.
    - y = (p*INV6 + 2^15) >>> 16.
  - Rounding is round-half-up via add-then-arithmetic-shift.
  - All results saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before output.
  - BYPASS = x unchanged.
- Lanes are independent and identical; all lanes share the beat's mode, valid and last.
- Simultaneous events:
  - An accepted tlast beat and the next beat's mode sample can occur on consecutive cycles with no bubble.
  - An input accept and an output accept in the same cycle while the pipeline is full is permitted without a stall.

Test Plan:
- HSWISH, LANES=1, x = 0x0100 (1.0), 0xFC00 (-4.0), 0x0800 (8.0), 0xFE80 (-1.5) -> outputs 0x00AB (171), 0x0000, 0x0800, 0xFFA0 (-96), in order, each at latency 3.
- Mode sweep, one packet per mode:
  - RELU x=0xFB00 -> 0x0000.
  - RELU6 x=0x0700 -> 0x0600.
  - HSIGMOID x=0x0000 -> 0x0080.
  - BYPASS x=0x8001 -> 0x8001.
  - Mode 6 x=0x1234 -> 0x1234 plus a single cfg_err pulse.
- Mode latching: a 4-beat packet with mode=RELU where cfg_mode switches to HSWISH after beat 1 -> all 4 beats processed as RELU; the next packet uses HSWISH. tlast appears only on output beat 4.
- Backpressure: 64 random beats, m_axis_tready random at 50% -> output sequence equals the golden model with no loss or duplication. Data stays stable during stalls. Full-rate throughput when ready is held at 1.
- Saturation/extremes, LANES=4: HSWISH lanes {0x7FFF, 0x8000, 0x0300, 0xFD00}:
  - Lane 0: 0x7FFF*6/6 -> 0x7FFF after rounding/saturation check.
  - Lane 1: 0x0000.
  - Lane 2: 0x0300 (3*6/6).
  - Lane 3: 0x0000.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> m_axis_tvalid=0 immediately. After release with no input, no output appears. The next packet re-latches its mode.
